// File: rtl/contour_pkg.sv
// Shared types, palettes and defaults for the final pixel compositing stage.
// Palette entries are packed 24-bit {r, g, b}; background index 4'hf is black.
package contour_pkg;

    localparam int         DEF_FADE_LEVELS     = 8;
    localparam int         DEF_FRAMES_PER_STEP = 4;
    localparam logic [3:0] DEF_TRANSPARENT_IDX = 4'h0;

    localparam logic [3:0] BG_START    = 4'd0;
    localparam logic [3:0] BG_INGAME   = 4'd1;
    localparam logic [3:0] BG_GAMEOVER = 4'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [23:0] BG_PALETTE [16] = '{
        24'h102040, 24'hFFFFFF, 24'h808080, 24'h3060A0,
        24'hC02020, 24'h20C020, 24'h2020C0, 24'hFFD700,
        24'h8B4513, 24'h87CEEB, 24'h228B22, 24'hF0E68C,
        24'h4B0082, 24'hFF8C00, 24'hA9A9A9, 24'h000000
    };

    // Entry 0 is the transparent key and never reaches the screen.
    localparam logic [23:0] SPRITE_PALETTE [16] = '{
        24'hFF00FF, 24'hFFFFFF, 24'hE0C090, 24'h0000FF,
        24'hFF0000, 24'h00FF00, 24'hFFFF00, 24'h00FFFF,
        24'h804000, 24'h404040, 24'hFF8080, 24'h80FF80,
        24'h8080FF, 24'hC0C0C0, 24'h600060, 24'h101010
    };

    function automatic rgb_t bg_color(input logic [3:0] idx);
        return rgb_t'(BG_PALETTE[idx]);
    endfunction

    function automatic rgb_t sprite_color(input logic [3:0] idx);
        return rgb_t'(SPRITE_PALETTE[idx]);
    endfunction

endpackage

// File: rtl/fade_controller.sv
// Frame-synchronous fade sequencer: detects frame starts, paces fade steps,
// and owns the brightness level and the background select.
module fade_controller
    import contour_pkg::*;
#(
    parameter int FADE_LEVELS     = DEF_FADE_LEVELS,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [3:0] bg_req,
    input  logic       bg_req_valid,
    output logic [3:0] current_bg,
    output logic [3:0] level,
    output logic       fade_busy,
    output state_t     state
);

    localparam logic [3:0] LEVEL_MAX = 4'(FADE_LEVELS);
    localparam logic [3:0] CNT_LAST  = 4'(FRAMES_PER_STEP - 1);

    state_t     state_q, state_d;
    logic [3:0] level_q, level_d;
    logic [3:0] bg_q, bg_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       origin_q, origin_d;
    logic       at_origin;
    logic       frame_tick;
    logic       step;

    assign at_origin  = (draw_x == 10'd0) && (draw_y == 10'd0);
    // Edge-detect so a (0,0) held across both Clk cycles of a pixel ticks once.
    assign frame_tick = at_origin && !origin_q;
    assign step       = frame_tick && (cnt_q == CNT_LAST);

    always_comb begin
        origin_d  = at_origin;
        state_d   = state_q;
        level_d   = level_q;
        bg_d      = bg_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;

        if (frame_tick) begin
            cnt_d = step ? 4'd0 : cnt_q + 4'd1;
        end

        // A step landing on the cycle a state is entered is consumed by the old state.
        case (state_q)
            IDLE: begin
                if (bg_req_valid && (bg_req != bg_q)) begin
                    pending_d = bg_req;
                    state_d   = FADE_OUT;
                    cnt_d     = 4'd0;
                end
            end
            FADE_OUT: begin
                if (step) begin
                    if (level_q != 4'd0) begin
                        level_d = level_q - 4'd1;
                    end
                    if (level_d == 4'd0) begin
                        state_d = SWAP;
                    end
                end
            end
            SWAP: begin
                if (frame_tick) begin
                    bg_d    = pending_q;
                    state_d = FADE_IN;
                end
            end
            FADE_IN: begin
                if (step) begin
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + 4'd1;
                    end
                    if (level_d == LEVEL_MAX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            level_q   <= LEVEL_MAX;
            bg_q      <= BG_START;
            pending_q <= BG_START;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            origin_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            bg_q      <= bg_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            origin_q  <= origin_d;
        end
    end

    assign current_bg = bg_q;
    assign level      = level_q;
    assign fade_busy  = busy_q;
    assign state      = state_q;

endmodule

// File: rtl/pixel_compositor.sv
// Final VGA stage: aligns blanking with RAM latency, layers sprites over the
// background, maps palette indices to RGB and applies the fade level.
module pixel_compositor
    import contour_pkg::*;
#(
    parameter int         FADE_LEVELS     = DEF_FADE_LEVELS,
    parameter int         FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter logic [3:0] TRANSPARENT_IDX = DEF_TRANSPARENT_IDX
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank_n,
    input  logic [3:0] background_data,
    input  logic       is_background,
    input  logic [3:0] player_data,
    input  logic       is_player,
    input  logic [3:0] enemy_data,
    input  logic       is_enemy,
    input  logic [3:0] bg_req,
    input  logic       bg_req_valid,
    output logic [3:0] current_bg,
    output logic       fade_busy,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output state_t     fade_state,
    output logic [3:0] fade_level
);

    localparam int FADE_SHIFT = $clog2(FADE_LEVELS);

    logic [3:0] level;
    logic       blank_q, blank_d;
    rgb_t       rgb_q, rgb_d;
    rgb_t       layer_rgb;

    // Truncating scale; at full level the product shifts back to c exactly.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] lvl);
        logic [11:0] prod;
        prod = {4'd0, c} * {8'd0, lvl};
        prod = prod >> FADE_SHIFT;
        return prod[7:0];
    endfunction

    fade_controller #(
        .FADE_LEVELS    (FADE_LEVELS),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_fade (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .draw_x      (DrawX),
        .draw_y      (DrawY),
        .bg_req      (bg_req),
        .bg_req_valid(bg_req_valid),
        .current_bg  (current_bg),
        .level       (level),
        .fade_busy   (fade_busy),
        .state       (fade_state)
    );

    // Stage 1 holds blank_n so it lines up with RAM data arriving one cycle late.
    always_comb begin
        blank_d   = blank_n;
        layer_rgb = '0;
        if (is_player && (player_data != TRANSPARENT_IDX)) begin
            layer_rgb = sprite_color(player_data);
        end else if (is_enemy && (enemy_data != TRANSPARENT_IDX)) begin
            layer_rgb = sprite_color(enemy_data);
        end else if (is_background) begin
            layer_rgb = bg_color(background_data);
        end

        rgb_d = '0;
        if (blank_q) begin
            rgb_d.r = scale(layer_rgb.r, level);
            rgb_d.g = scale(layer_rgb.g, level);
            rgb_d.b = scale(layer_rgb.b, level);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

    assign VGA_R      = rgb_q.r;
    assign VGA_G      = rgb_q.g;
    assign VGA_B      = rgb_q.b;
    assign fade_level = level;

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: directed literal checks plus a
// randomized run compared every cycle against a frame-count based reference.
`timescale 1ns/1ps
module tb_pixel_compositor;
    import contour_pkg::*;

    localparam int FL  = 8;
    localparam int FPS = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       blank_n = 1'b0;
    logic [3:0] background_data = '0;
    logic       is_background = 1'b0;
    logic [3:0] player_data = '0;
    logic       is_player = 1'b0;
    logic [3:0] enemy_data = '0;
    logic       is_enemy = 1'b0;
    logic [3:0] bg_req = '0;
    logic       bg_req_valid = 1'b0;
    logic [3:0] current_bg;
    logic       fade_busy;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    state_t     fade_state;
    logic [3:0] fade_level;

    int n_cmp = 0;
    int n_bad = 0;
    int pix_ctr = 0;
    bit rand_mode = 0;
    bit rand_req = 0;
    int budget;

    pixel_compositor dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .blank_n        (blank_n),
        .background_data(background_data),
        .is_background  (is_background),
        .player_data    (player_data),
        .is_player      (is_player),
        .enemy_data     (enemy_data),
        .is_enemy       (is_enemy),
        .bg_req         (bg_req),
        .bg_req_valid   (bg_req_valid),
        .current_bg     (current_bg),
        .fade_busy      (fade_busy),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .fade_state     (fade_state),
        .fade_level     (fade_level)
    );

    // ---------------- clock ----------------
    always #10 Clk = ~Clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_scale(input logic [7:0] c, input int lvl);
        int v;
        v = (int'(c) * lvl) / FL;
        return 8'(v);
    endfunction

    // Brightness as a function of frame ticks counted since the request.
    function automatic int level_at(input int k);
        int down;
        int up;
        down = FL * FPS;
        if (k <= down) return FL - k / FPS;
        up = (k - down) / FPS;
        return (up > FL) ? FL : up;
    endfunction

    bit          m_blank_d = 0;
    bit          m_prev0 = 0;
    bit          m_busy = 0;
    bit          m_zero;
    bit          m_tick;
    int          m_k = 0;
    int          m_level = FL;
    logic [3:0]  m_bg = 4'd0;
    logic [3:0]  m_pending = 4'd0;
    logic [23:0] m_rgb = '0;
    logic [23:0] m_src;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_blank_d = 0;
            m_prev0   = 0;
            m_busy    = 0;
            m_k       = 0;
            m_level   = FL;
            m_bg      = 4'd0;
            m_pending = 4'd0;
            m_rgb     = '0;
        end else begin
            if (is_player && player_data != 4'h0)     m_src = SPRITE_PALETTE[player_data];
            else if (is_enemy && enemy_data != 4'h0)  m_src = SPRITE_PALETTE[enemy_data];
            else if (is_background)                   m_src = BG_PALETTE[background_data];
            else                                      m_src = 24'h0;
            m_rgb = m_blank_d ? {m_scale(m_src[23:16], m_level), m_scale(m_src[15:8], m_level),
                                 m_scale(m_src[7:0], m_level)} : 24'h0;
            m_blank_d = blank_n;

            m_zero  = (DrawX == 10'd0) && (DrawY == 10'd0);
            m_tick  = m_zero && !m_prev0;
            m_prev0 = m_zero;
            if (!m_busy) begin
                if (bg_req_valid && bg_req != m_bg) begin
                    m_busy    = 1;
                    m_k       = 0;
                    m_pending = bg_req;
                end
            end else if (m_tick) begin
                m_k++;
                m_level = level_at(m_k);
                if (m_k == FL * FPS + 1) m_bg = m_pending;
                if (m_k == 2 * FL * FPS) m_busy = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (Reset_n) begin
            check("vga_r", VGA_R, m_rgb[23:16]);
            check("vga_g", VGA_G, m_rgb[15:8]);
            check("vga_b", VGA_B, m_rgb[7:0]);
            check("current_bg", current_bg, m_bg);
            check("fade_busy", fade_busy, m_busy);
            check("fade_level", fade_level, m_level);
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge Clk);
        #1;
        pix_ctr++;
        DrawX = 10'((pix_ctr >> 1) % 8);
        DrawY = 10'((pix_ctr >> 4) % 4);
        bg_req_valid = 1'b0;
        if (rand_mode) begin
            blank_n         = ($urandom_range(0, 9) != 0);
            is_player       = 1'($urandom_range(0, 1));
            player_data     = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            is_enemy        = 1'($urandom_range(0, 1));
            enemy_data      = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            is_background   = ($urandom_range(0, 3) != 0);
            background_data = 4'($urandom_range(0, 15));
        end
        if (rand_req && $urandom_range(0, 149) == 0) begin
            bg_req       = 4'($urandom_range(0, 2));
            bg_req_valid = 1'b1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Model pins: hand-computed values.
        check("pin_scale_ff_l3", m_scale(8'hFF, 3), 8'h5F);
        check("pin_scale_80_l5", m_scale(8'h80, 5), 8'h50);
        check("pin_level_k20", level_at(20), 3);
        check("pin_level_k32", level_at(32), 0);
        check("pin_level_k36", level_at(36), 1);
        check("pin_level_k64", level_at(64), 8);

        repeat (3) cyc();
        check("reset_vga", {VGA_R, VGA_G, VGA_B}, 24'h0);
        check("reset_bg", current_bg, 4'd0);
        check("reset_busy", fade_busy, 1'b0);
        check("reset_level", fade_level, 4'd8);
        Reset_n = 1'b1;

        // Background only.
        blank_n = 1'b1; is_background = 1'b1; background_data = 4'h3;
        repeat (3) cyc();
        check("bg3_rgb", {VGA_R, VGA_G, VGA_B}, 24'h3060A0);

        // Sprite priority and transparency.
        is_player = 1'b1; player_data = 4'd5; is_enemy = 1'b1; enemy_data = 4'd7;
        repeat (2) cyc();
        check("player_over_enemy", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
        player_data = 4'd0;
        repeat (2) cyc();
        check("enemy_when_player_clear", {VGA_R, VGA_G, VGA_B}, 24'h00FFFF);
        enemy_data = 4'd0;
        repeat (2) cyc();
        check("bg_when_sprites_clear", {VGA_R, VGA_G, VGA_B}, 24'h3060A0);

        // One-cycle blank appears exactly two cycles later, for one cycle.
        blank_n = 1'b0;
        cyc();
        blank_n = 1'b1;
        check("blank_lat1", {VGA_R, VGA_G, VGA_B}, 24'h3060A0);
        cyc();
        check("blank_lat2", {VGA_R, VGA_G, VGA_B}, 24'h0);
        cyc();
        check("blank_lat3", {VGA_R, VGA_G, VGA_B}, 24'h3060A0);

        // Request equal to current background is ignored.
        bg_req = 4'd0; bg_req_valid = 1'b1;
        cyc();
        cyc();
        check("same_req_ignored", fade_busy, 1'b0);

        // Full fade to game-over background over a white background.
        is_player = 1'b0; is_enemy = 1'b0; background_data = 4'h1;
        bg_req = BG_GAMEOVER; bg_req_valid = 1'b1;
        cyc();
        check("busy_rise", fade_busy, 1'b1);

        budget = 0;
        while (!(m_busy && m_level == 3) && budget < 6000) begin cyc(); budget++; end
        if (budget >= 6000) timeout("wait_level3");
        repeat (2) cyc();
        check("white_at_level3", VGA_R, 8'h5F);

        // Request during FADE_OUT is dropped.
        bg_req = BG_INGAME; bg_req_valid = 1'b1;
        cyc();

        budget = 0;
        while (m_k < FL * FPS + 1 && budget < 6000) begin cyc(); budget++; end
        if (budget >= 6000) timeout("wait_swap");
        check("swap_to_gameover", current_bg, 4'd2);

        budget = 0;
        while (m_busy && budget < 6000) begin cyc(); budget++; end
        if (budget >= 6000) timeout("wait_fade_in");
        check("fade_done_busy", fade_busy, 1'b0);
        check("fade_done_level", fade_level, 4'd8);
        check("fade_done_bg", current_bg, 4'd2);

        // Randomized layers during a second fade, then reset mid-fade.
        rand_mode = 1'b1;
        bg_req = BG_START; bg_req_valid = 1'b1;
        cyc();
        check("busy_rise2", fade_busy, 1'b1);
        budget = 0;
        while (m_k < 10 && budget < 3000) begin cyc(); budget++; end
        if (budget >= 3000) timeout("wait_mid_fade");
        #5;
        Reset_n = 1'b0;
        #1;
        check("async_rst_vga", {VGA_R, VGA_G, VGA_B}, 24'h0);
        check("async_rst_bg", current_bg, 4'd0);
        check("async_rst_busy", fade_busy, 1'b0);
        check("async_rst_level", fade_level, 4'd8);
        repeat (2) cyc();
        Reset_n = 1'b1;

        // Free-running random layers and random requests.
        rand_req = 1'b1;
        repeat (6000) cyc();
        rand_req = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
